// File: rtl/collision_scanner.sv
// collision_scanner
// On a start request the block captures every wall and tank position. It then
// checks one (tank, wall) pair per cycle. For each tank it looks at the
// rectangle the tank would occupy after one STEP in its current direction.
// When the walk is complete it publishes a registered per-tank move
// permission and pulses done for one cycle.
// Build option: defining the macro COLLISION_TANK_TANK_EN adds a
// tank-versus-tank pass. That pass takes one cycle per tank and sits between
// the wall walk and completion.
module collision_scanner #(
    parameter int NUM_WALLS = 4,
    parameter int NUM_TANKS = 2,
    parameter int STEP      = 1,
    parameter int TANK_W    = 32,
    parameter int TANK_H    = 32,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [10*NUM_WALLS-1:0] wall_x,
    input  logic [10*NUM_WALLS-1:0] wall_y,
    input  logic [NUM_WALLS-1:0]    wall_vert,
    input  logic [10*NUM_TANKS-1:0] tank_x,
    input  logic [10*NUM_TANKS-1:0] tank_y,
    input  logic [3*NUM_TANKS-1:0]  tank_dir,
    output logic [NUM_TANKS-1:0]    can_move,
    output logic                    busy,
    output logic                    done
);

    localparam int TI_W = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam int WI_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
    localparam logic [TI_W-1:0] LAST_T = TI_W'(NUM_TANKS - 1);
    localparam logic [WI_W-1:0] LAST_W = WI_W'(NUM_WALLS - 1);

    // The candidate position is 11-bit signed. Comparisons are done one bit
    // wider so that coordinate-plus-size sums cannot wrap.
    localparam logic signed [10:0] L_STEP       = 11'(STEP);
    localparam logic signed [11:0] L_TANK_W     = 12'(TANK_W);
    localparam logic signed [11:0] L_TANK_H     = 12'(TANK_H);
    localparam logic signed [11:0] L_SCREEN_W   = 12'(SCREEN_W);
    localparam logic signed [11:0] L_SCREEN_H   = 12'(SCREEN_H);
    localparam logic signed [11:0] L_WALL_LONG  = 12'sd64;
    localparam logic signed [11:0] L_WALL_SHORT = 12'sd32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
`ifdef COLLISION_TANK_TANK_EN
        S_TT   = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    logic [TI_W-1:0]         r_t;
    logic [WI_W-1:0]         r_w;
    logic [NUM_TANKS-1:0]    r_blocked;
    logic [NUM_TANKS-1:0]    r_can_move;
    logic                    r_done;

    logic [10*NUM_WALLS-1:0] r_wall_x;
    logic [10*NUM_WALLS-1:0] r_wall_y;
    logic [NUM_WALLS-1:0]    r_wall_vert;
    logic [10*NUM_TANKS-1:0] r_tank_x;
    logic [10*NUM_TANKS-1:0] r_tank_y;
    logic [3*NUM_TANKS-1:0]  r_tank_dir;

    // Strict overlap: rectangles that only share an edge do not collide.
    function automatic logic rect_overlap(
        input logic signed [11:0] ax, input logic signed [11:0] ay,
        input logic signed [11:0] aw, input logic signed [11:0] ah,
        input logic signed [11:0] bx, input logic signed [11:0] by,
        input logic signed [11:0] bw, input logic signed [11:0] bh
    );
        return (ax < bx + bw) && (ax + aw > bx) &&
               (ay < by + bh) && (ay + ah > by);
    endfunction

    function automatic logic signed [11:0] ext_u10(input logic [9:0] v);
        return $signed({2'b00, v});
    endfunction

    logic [9:0]         w_tank_x, w_tank_y, w_wall_x, w_wall_y;
    logic [2:0]         w_dir;
    logic               w_wall_vert, w_active;
    logic signed [10:0] w_cand_x, w_cand_y;
    logic signed [11:0] w_cx, w_cy, w_wall_w, w_wall_h;
    logic               w_hit_wall, w_off_screen, w_pair_blocked;
    logic               w_last_t, w_last_w;

    // Select the current pair, form the tank's candidate rectangle and test it.
    always_comb begin
        // NOTE: every signal gets a value before any branch reads or modifies it, so no latch is inferred.
        w_tank_x    = r_tank_x[10*r_t +: 10];
        w_tank_y    = r_tank_y[10*r_t +: 10];
        w_dir       = r_tank_dir[3*r_t +: 3];
        w_wall_x    = r_wall_x[10*r_w +: 10];
        w_wall_y    = r_wall_y[10*r_w +: 10];
        w_wall_vert = r_wall_vert[r_w];
        w_active    = (w_dir >= 3'd1) && (w_dir <= 3'd4);
        w_cand_x    = $signed({1'b0, w_tank_x});
        w_cand_y    = $signed({1'b0, w_tank_y});
        case (w_dir)
            3'd1:    w_cand_y = w_cand_y - L_STEP;
            3'd2:    w_cand_x = w_cand_x + L_STEP;
            3'd3:    w_cand_x = w_cand_x - L_STEP;
            3'd4:    w_cand_y = w_cand_y + L_STEP;
            default: ;
        endcase
        w_cx         = {w_cand_x[10], w_cand_x};
        w_cy         = {w_cand_y[10], w_cand_y};
        w_wall_w     = w_wall_vert ? L_WALL_SHORT : L_WALL_LONG;
        w_wall_h     = w_wall_vert ? L_WALL_LONG : L_WALL_SHORT;
        w_hit_wall   = rect_overlap(w_cx, w_cy, L_TANK_W, L_TANK_H,
                                    ext_u10(w_wall_x), ext_u10(w_wall_y),
                                    w_wall_w, w_wall_h);
        w_off_screen = (w_cx < 12'sd0) || (w_cy < 12'sd0) ||
                       (w_cx + L_TANK_W > L_SCREEN_W) ||
                       (w_cy + L_TANK_H > L_SCREEN_H);
        w_pair_blocked = w_active &&
                         (w_hit_wall || ((r_w == '0) && w_off_screen));
        w_last_t = (r_t == LAST_T);
        w_last_w = (r_w == LAST_W);
    end

`ifdef COLLISION_TANK_TANK_EN
    logic w_tt_blocked;

    // Test the candidate of tank r_t against the current rectangle of every other tank.
    always_comb begin
        w_tt_blocked = 1'b0;
        for (int u = 0; u < NUM_TANKS; u++) begin
            if ((u != int'(r_t)) &&
                rect_overlap(w_cx, w_cy, L_TANK_W, L_TANK_H,
                             ext_u10(r_tank_x[10*u +: 10]),
                             ext_u10(r_tank_y[10*u +: 10]),
                             L_TANK_W, L_TANK_H))
                w_tt_blocked = 1'b1;
        end
        w_tt_blocked = w_tt_blocked && w_active;
    end
`endif

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic and busy flag.
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (start) w_state_next = S_SCAN;
            S_SCAN: begin
                if (w_last_w && w_last_t) begin
`ifdef COLLISION_TANK_TANK_EN
                    w_state_next = S_TT;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef COLLISION_TANK_TANK_EN
            S_TT:   if (w_last_t) w_state_next = S_DONE;
`endif
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pair counters, sticky blocked flags and published results.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_t        <= '0;
            r_w        <= '0;
            r_blocked  <= '0;
            r_can_move <= '1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_blocked <= '0;
                        r_t       <= '0;
                        r_w       <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_pair_blocked) r_blocked[r_t] <= 1'b1;
                    if (w_last_w) begin
                        r_w <= '0;
                        r_t <= w_last_t ? '0 : r_t + 1'b1;
                    end else begin
                        r_w <= r_w + 1'b1;
                    end
                end
`ifdef COLLISION_TANK_TANK_EN
                S_TT: begin
                    if (w_tt_blocked) r_blocked[r_t] <= 1'b1;
                    r_t <= w_last_t ? '0 : r_t + 1'b1;
                end
`endif
                S_DONE: begin
                    r_can_move <= ~r_blocked;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Capture the playfield when a scan is accepted; later input changes are ignored.
    // NOTE: these are pure data registers that are always loaded before they are read, so they have no reset.
    always_ff @(posedge Clk) begin
        if ((r_state == S_IDLE) && start) begin
            r_wall_x    <= wall_x;
            r_wall_y    <= wall_y;
            r_wall_vert <= wall_vert;
            r_tank_x    <= tank_x;
            r_tank_y    <= tank_y;
            r_tank_dir  <= tank_dir;
        end
    end

    assign can_move = r_can_move;
    assign done     = r_done;

endmodule
